// File: rtl/seq_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_unit_pkg                                                    |
// | Brief    : State and operation codes shared by the seq_unit_p slice.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package seq_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_DEC = 2'b01,
        OP_SHL = 2'b10,
        OP_ACC = 2'b11
    } op_t;

endpackage
`default_nettype wire

// File: rtl/seq_unit_p_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_unit_p_if                                                   |
// | Brief    : Stimulus/result bundle between the sequencer and its users.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface seq_unit_p_if #(
    parameter int W  = 8,
    parameter int SW = 3
);
    logic [W-1:0]  x;
    logic [1:0]    on;
    logic          start;
    logic          abort;
    logic [W-1:0]  y;
    logic [SW-1:0] s;
    logic          b;
    logic [1:0]    regime;
    logic          active;

    modport master (
        output x, on, start, abort,
        input  y, s, b, regime, active
    );

    modport slave (
        input  x, on, start, abort,
        output y, s, b, regime, active
    );
endinterface
`default_nettype wire

// File: rtl/seq_unit_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_unit_dp                                                     |
// | Brief    : Result, operand, step counter and sticky flag with the op mux.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_unit_dp
    import seq_unit_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load_i,
    input  wire logic          step_i,
    input  wire logic [W-1:0]  x_i,
    input  wire op_t           op_i,
    output logic      [W-1:0]  y_o,
    output logic      [SW-1:0] s_o,
    output logic               b_o
);

    logic [W-1:0]  y_q,  y_d;
    logic [W-1:0]  xr_q, xr_d;
    logic [SW-1:0] s_q,  s_d;
    logic          b_q,  b_d;
    op_t           op_q, op_d;

    logic [W-1:0]  w_next_y;
    logic          w_flag;

    // Candidate step result and the carry/borrow/shift-out it produces.
    always_comb begin
        w_next_y = y_q;
        w_flag   = 1'b0;
        case (op_q)
            OP_INC: {w_flag, w_next_y} = {1'b0, y_q} + (W+1)'(1);
            OP_DEC: begin
                w_next_y = y_q - W'(1);
                w_flag   = (y_q == '0);
            end
            OP_SHL: begin
                w_next_y = {y_q[W-2:0], 1'b0};
                w_flag   = y_q[W-1];
            end
            OP_ACC: {w_flag, w_next_y} = {1'b0, y_q} + {1'b0, xr_q};
            default: begin
                w_next_y = y_q;
                w_flag   = 1'b0;
            end
        endcase
    end

    always_comb begin
        y_d  = y_q;
        xr_d = xr_q;
        s_d  = s_q;
        b_d  = b_q;
        op_d = op_q;
        if (load_i) begin
            y_d  = x_i;
            xr_d = x_i;
            op_d = op_i;
            s_d  = '0;
            b_d  = 1'b0;
        end else if (step_i) begin
            y_d = w_next_y;
            s_d = s_q + SW'(1);
            b_d = b_q | w_flag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            xr_q <= '0;
            s_q  <= '0;
            b_q  <= 1'b0;
            op_q <= OP_INC;
        end else begin
            y_q  <= y_d;
            xr_q <= xr_d;
            s_q  <= s_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    assign y_o = y_q;
    assign s_o = s_q;
    assign b_o = b_q;

endmodule
`default_nettype wire

// File: rtl/seq_unit_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_unit_p                                                      |
// | Brief    : Start/run/done sequencer applying one of four ops STEPS times.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_unit_p
    import seq_unit_pkg::*;
#(
    parameter int W     = 8,
    parameter int SW    = 3,
    parameter int STEPS = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    seq_unit_p_if.slave bus
);

    if (STEPS < 1 || STEPS > (2**SW) - 1) begin : g_steps_range_check
        $error("seq_unit_p: STEPS must lie in 1..2**SW-1");
    end

    state_t        state_q, state_d;
    logic          w_load;
    logic          w_step;
    logic          w_last;
    logic [SW-1:0] w_s;

    assign w_last = ({1'b0, w_s} + (SW+1)'(1)) == (SW+1)'(STEPS);

    // Abort outranks both the step and the completion; DONE waits for start to drop.
    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    seq_unit_dp #(
        .W  (W),
        .SW (SW)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_load),
        .step_i (w_step),
        .x_i    (bus.x),
        .op_i   (op_t'(bus.on)),
        .y_o    (bus.y),
        .s_o    (w_s),
        .b_o    (bus.b)
    );

    assign bus.s      = w_s;
    assign bus.regime = state_q;
    assign bus.active = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: doc/seq_unit_p.md
Name: seq_unit_p

Overview:
Parametrised successor of the team's single-width operational-automaton block. The data path and control path are fused behind one generic interface.
- On a start request it loads an operand and applies one of four selectable operations a fixed number of steps.
- It exposes the result, a step counter, a sticky overflow flag, and its control state.
- It sits at top level between the external stimulus ports (x, on, start) and the result/status consumers.

Parameters:
W, 8, data width of x and y
SW, 3, width of step counter s
STEPS, 5, number of RUN iterations; legal range 1..2**SW-1 (elaboration-time check)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
x  input  W  operand, sampled only on the load edge
on  input  2  operation select, latched on the load edge
start  input  1  level request; acted on only in IDLE
abort  input  1  cancels an operation in progress
y  output  W  result register
s  output  SW  completed-step counter
b  output  1  sticky overflow/carry/borrow flag
regime  output  2  current control state code
active  output  1  high while regime==RUN

Behaviour:
- Reset (async, rst=1):
  - y=0, s=0, b=0, regime=IDLE(00), active=0.
  - Internal operand register xr=0; latched op=00.
  - Takes effect immediately, including mid-RUN.
- All outputs are registered. active is decoded from the state register: active=(state==RUN), so it has no combinational path from inputs.
- States:
  - IDLE=00, RUN=01, DONE=10.
  - 11 is illegal: next state is IDLE; y, s and b hold.
- IDLE:
  - If start=1 at an edge (abort ignored here): y<=x, xr<=x, op<=on, s<=0, b<=0, state<=RUN.
  - Otherwise all registers hold.
- RUN, with abort=0, at each edge:
  - Apply op to y (below) and s<=s+1.
  - If s+1==STEPS, state<=DONE.
  - Exactly STEPS RUN cycles; the first update lands on the edge after the load edge.
- RUN, with abort=1 at an edge: no op applied; y and s hold; state<=IDLE. abort takes priority over the step update and over the completion transition.
- Operations (all arithmetic is modulo 2**W):
  - 00 inc: y<=y+1; b|=carry-out.
  - 01 dec: y<=y-1; b|=borrow (y==0 before the step).
  - 10 shl: y<={y[W-2:0],0}; b|=y[W-1].
  - 11 acc: y<=y+xr; b|=carry-out. xr is frozen, so x changes during RUN have no effect.
- b is only set during RUN and only cleared on a load or on reset.
- DONE:
  - y, s and b hold.
  - If start=0, state<=IDLE; otherwise stay in DONE.
  - This handshake means a start held high never retriggers; start must drop and rise again.
  - abort is ignored in DONE.
- on and x are ignored outside the load edge.
- s never wraps, since STEPS<=2**SW-1.

Decomposition:
- Package seq_unit_pkg holds:
  - state codes ST_IDLE/ST_RUN/ST_DONE (2-bit);
  - op codes OP_INC/OP_DEC/OP_SHL/OP_ACC.
- Natural split into one sub-module, seq_unit_dp: the W-bit data path (y, xr, s, b, op mux) driven by control strobes load, step and op.
- The FSM (state, done/abort decisions) stays in seq_unit_p.

Test Plan:
(W=8, SW=3, STEPS=5)
- inc: x=0x10, on=00, 1-cycle start pulse.
  - active high exactly 5 cycles.
  - Then regime=10, y=0x15, s=5, b=0.
  - regime returns to 00 one edge after start=0.
- dec with borrow: x=0x02, on=01 → y=0xFD, s=5, b=1 (set on the 3rd step, stays set).
- shl: x=0x81, on=10 → sequence 0x02, 0x04, 0x08, 0x10, 0x20; final y=0x20, b=1.
- acc: x=0x40, on=11; x is changed to 0xFF during RUN.
  - Sequence 0x80, 0xC0, 0x00, 0x40, 0x80; final y=0x80, b=1, so xr is shown frozen.
- abort/handshake:
  - inc with x=0x00, abort asserted in the 3rd RUN cycle → y=0x02, s=2, regime=00 next edge.
  - start held high through DONE → regime stays 10, no restart.
- reset mid-RUN: rst pulsed asynchronously between edges → y=0, s=0, b=0, regime=00, active=0 immediately, without waiting for the next edge.
  - Next start begins a clean operation.
